// File: rtl/fft_pkg.sv
// Shared definitions for the 16-point radix-4 FFT datapath and its input buffer.
package fft_pkg;

  localparam int FFT_N      = 16;
  localparam int FFT_LOG4N  = 2;
  localparam int FFT_DATA_W = 16;
  localparam int FFT_AW     = 4;

  typedef struct packed {
    logic signed [FFT_DATA_W-1:0] re;
    logic signed [FFT_DATA_W-1:0] im;
  } cplx_t;

  // Sample k = 4*a1 + a0 maps to address 4*a0 + a1.
  function automatic logic [FFT_AW-1:0] digit_rev4(input logic [FFT_AW-1:0] idx);
    return {idx[1:0], idx[3:2]};
  endfunction

endpackage

// File: rtl/fft_in_bank.sv
// One 16-entry complex register bank: single write port, full parallel read port,
// contents cleared by asynchronous reset.
module fft_in_bank
  import fft_pkg::*;
#(
  parameter int DATA_W = FFT_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we_i,
  input  logic [FFT_AW-1:0] waddr_i,
  input  logic [DATA_W-1:0] wre_i,
  input  logic [DATA_W-1:0] wim_i,
  output logic [DATA_W-1:0] rre_o [0:FFT_N-1],
  output logic [DATA_W-1:0] rim_o [0:FFT_N-1]
);

  logic signed [DATA_W-1:0] re_q [0:FFT_N-1];
  logic signed [DATA_W-1:0] im_q [0:FFT_N-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FFT_N; i++) begin
        re_q[i] <= '0;
        im_q[i] <= '0;
      end
    end else if (we_i) begin
      re_q[waddr_i] <= wre_i;
      im_q[waddr_i] <= wim_i;
    end
  end

  always_comb begin
    for (int i = 0; i < FFT_N; i++) begin
      rre_o[i] = re_q[i];
      rim_o[i] = im_q[i];
    end
  end

endmodule

// File: rtl/fft_input_buffer.sv
// Ping-pong frame assembler feeding the 16-point FFT stage.
// Build option: define FFT_IN_DIGIT_REVERSE_EN to store frames in base-4 digit-reversed order.
module fft_input_buffer
  import fft_pkg::*;
#(
  parameter int DATA_W = FFT_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_real,
  input  logic [DATA_W-1:0] in_imag,
  output logic              frame_valid,
  input  logic              frame_ready,
  output logic [DATA_W-1:0] real_frame [0:FFT_N-1],
  output logic [DATA_W-1:0] imag_frame [0:FFT_N-1],
  output logic [3:0]        fill_count
);

  logic [1:0]        bank_full_q, bank_full_d;
  logic              wr_sel_q, wr_sel_d;
  logic              rd_sel_q, rd_sel_d;
  logic [FFT_AW-1:0] wr_cnt_q, wr_cnt_d;

  logic              accept;
  logic              consume;
  logic [FFT_AW-1:0] wr_addr;

  logic [DATA_W-1:0] b0_re [0:FFT_N-1];
  logic [DATA_W-1:0] b0_im [0:FFT_N-1];
  logic [DATA_W-1:0] b1_re [0:FFT_N-1];
  logic [DATA_W-1:0] b1_im [0:FFT_N-1];

  // Handshake outputs come straight from registers, never from in_valid/frame_ready.
  assign in_ready    = !bank_full_q[wr_sel_q];
  assign frame_valid = bank_full_q[rd_sel_q];
  assign fill_count  = wr_cnt_q;

  assign accept  = in_valid && in_ready;
  assign consume = frame_valid && frame_ready;

`ifdef FFT_IN_DIGIT_REVERSE_EN
  assign wr_addr = digit_rev4(wr_cnt_q);
`else
  assign wr_addr = wr_cnt_q;
`endif

  always_comb begin
    bank_full_d = bank_full_q;
    wr_sel_d    = wr_sel_q;
    rd_sel_d    = rd_sel_q;
    wr_cnt_d    = wr_cnt_q;
    if (accept) begin
      wr_cnt_d = wr_cnt_q + 4'd1;
      if (wr_cnt_q == 4'd15) begin
        bank_full_d[wr_sel_q] = 1'b1;
        wr_sel_d              = !wr_sel_q;
      end
    end
    // Consume and a 16th accept never collide: one targets a full bank, the other an empty one.
    if (consume) begin
      bank_full_d[rd_sel_q] = 1'b0;
      rd_sel_d              = !rd_sel_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bank_full_q <= '0;
      wr_sel_q    <= 1'b0;
      rd_sel_q    <= 1'b0;
      wr_cnt_q    <= '0;
    end else begin
      bank_full_q <= bank_full_d;
      wr_sel_q    <= wr_sel_d;
      rd_sel_q    <= rd_sel_d;
      wr_cnt_q    <= wr_cnt_d;
    end
  end

  fft_in_bank #(.DATA_W(DATA_W)) u_bank0 (
    .clk     (clk),
    .reset   (reset),
    .we_i    (accept && !wr_sel_q),
    .waddr_i (wr_addr),
    .wre_i   (in_real),
    .wim_i   (in_imag),
    .rre_o   (b0_re),
    .rim_o   (b0_im)
  );

  fft_in_bank #(.DATA_W(DATA_W)) u_bank1 (
    .clk     (clk),
    .reset   (reset),
    .we_i    (accept && wr_sel_q),
    .waddr_i (wr_addr),
    .wre_i   (in_real),
    .wim_i   (in_imag),
    .rre_o   (b1_re),
    .rim_o   (b1_im)
  );

  always_comb begin
    for (int i = 0; i < FFT_N; i++) begin
      real_frame[i] = rd_sel_q ? b1_re[i] : b0_re[i];
      imag_frame[i] = rd_sel_q ? b1_im[i] : b0_im[i];
    end
  end

endmodule

// File: tb/tb_fft_input_buffer.sv
// Self-checking bench for fft_input_buffer: frame-queue reference model plus phase table.
module tb_fft_input_buffer;

  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_real;
  logic [DW-1:0] in_imag;
  logic          frame_valid;
  logic          frame_ready;
  logic [DW-1:0] real_frame [0:15];
  logic [DW-1:0] imag_frame [0:15];
  logic [3:0]    fill_count;

  fft_input_buffer #(.DATA_W(DW)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_real     (in_real),
    .in_imag     (in_imag),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .real_frame  (real_frame),
    .imag_frame  (imag_frame),
    .fill_count  (fill_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0][DW-1:0] re;
    logic [15:0][DW-1:0] im;
  } frame_t;

  typedef struct {
    bit v;
    bit r;
    int n;
    bit ir;
    bit fv;
    int fill;
    int cons;
  } phase_t;

  int     tests  = 0;
  int     failed = 0;
  int     samp   = 0;
  int     dut_cons = 0;
  frame_t full_q[$];
  frame_t cur;
  int     cnt = 0;
  phase_t tbl [9];

  function automatic int addr_of(input int k);
`ifdef FFT_IN_DIGIT_REVERSE_EN
    return (k % 4) * 4 + k / 4;
`else
    return k;
`endif
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_frame(input string nm, input frame_t e);
    int bad = -1;
    tests++;
    for (int j = 0; j < 16; j++)
      if (bad < 0 && (real_frame[j] !== e.re[j] || imag_frame[j] !== e.im[j])) bad = j;
    if (bad >= 0) begin
      failed++;
      $display("FAIL %s idx %0d: got re=%0h im=%0h, expected re=%0h im=%0h (t=%0t)",
               nm, bad, real_frame[bad], imag_frame[bad], e.re[bad], e.im[bad], $time);
    end
  endtask

  task automatic model_clear();
    full_q.delete();
    cur = '0;
    cnt = 0;
  endtask

  // Called at posedge+1 with inputs applied: compare, clock, then advance model.
  task automatic cyc(input bit v, input bit r);
    int  neg;
    bit  m_ir, m_fv;
    neg         = -samp;
    in_valid    = v;
    frame_ready = r;
    in_real     = samp[DW-1:0];
    in_imag     = neg[DW-1:0];
    m_ir = (full_q.size() < 2);
    m_fv = (full_q.size() > 0);
    #1;
    chk("in_ready", int'(in_ready), int'(m_ir));
    chk("frame_valid", int'(frame_valid), int'(m_fv));
    chk("fill_count", int'(fill_count), cnt);
    if (m_fv) chk_frame("frame_data", full_q[0]);
    if (frame_valid && r) dut_cons++;
    @(posedge clk);
    if (m_fv && r) void'(full_q.pop_front());
    if (v && m_ir) begin
      cur.re[addr_of(cnt)] = samp[DW-1:0];
      cur.im[addr_of(cnt)] = neg[DW-1:0];
      cnt++;
      samp++;
      if (cnt == 16) begin
        full_q.push_back(cur);
        cnt = 0;
      end
    end
    #1;
  endtask

  task automatic apply_reset();
    in_valid    = 1'b0;
    frame_ready = 1'b0;
    reset       = 1'b1;
    #1;
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_frame_valid", int'(frame_valid), 0);
    chk("rst_fill_count", int'(fill_count), 0);
    chk_frame("rst_frame", '0);
    model_clear();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    int     k;
    int     neg;
    int     c0;
    reset       = 1'b1;
    in_valid    = 1'b0;
    frame_ready = 1'b0;
    in_real     = '0;
    in_imag     = '0;
    tbl[0] = '{1, 0, 16, 1, 1, 0,  0};
    tbl[1] = '{1, 0, 15, 1, 1, 15, 0};
    tbl[2] = '{1, 1, 1,  1, 1, 0,  1};
    tbl[3] = '{1, 0, 16, 0, 1, 0,  0};
    tbl[4] = '{1, 0, 3,  0, 1, 0,  0};
    tbl[5] = '{1, 1, 1,  1, 1, 0,  1};
    tbl[6] = '{0, 1, 2,  1, 0, 0,  1};
    tbl[7] = '{1, 1, 64, 1, 1, 0,  3};
    tbl[8] = '{0, 1, 1,  1, 0, 0,  1};

    @(posedge clk);
    #1;
    apply_reset();

    // Natural order frame with explicit expected values.
    samp = 0;
    for (int i = 0; i < 16; i++) cyc(1'b1, 1'b1);
    in_valid = 1'b0;
    #1;
    chk("nat_frame_valid", int'(frame_valid), 1);
    for (int j = 0; j < 16; j++) begin
      k   = addr_of(j);
      neg = -k;
      chk($sformatf("nat_real[%0d]", j), int'(real_frame[j]), k);
      chk($sformatf("nat_imag[%0d]", j), int'(imag_frame[j]), int'(neg[DW-1:0]));
    end
    #1;
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b0);

    // Backpressure, simultaneous accept+consume, continuous stream.
    apply_reset();
    samp = 0;
    for (int p = 0; p < 9; p++) begin
      c0 = dut_cons;
      for (int i = 0; i < tbl[p].n; i++) cyc(tbl[p].v, tbl[p].r);
      chk($sformatf("ph%0d_in_ready", p), int'(in_ready), int'(tbl[p].ir));
      chk($sformatf("ph%0d_frame_valid", p), int'(frame_valid), int'(tbl[p].fv));
      chk($sformatf("ph%0d_fill_count", p), int'(fill_count), tbl[p].fill);
      chk($sformatf("ph%0d_consumes", p), dut_cons - c0, tbl[p].cons);
    end

    // Random valid gaps and frame_ready stalls.
    for (int i = 0; i < 400; i++)
      cyc($urandom_range(0, 99) < 65, $urandom_range(0, 99) < 30);

    // Mid-frame asynchronous reset, then a clean frame.
    apply_reset();
    for (int i = 0; i < 7; i++) cyc(1'b1, 1'b0);
    chk("pre_rst_fill", int'(fill_count), 7);
    apply_reset();
    for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
